sparse_chunk_writer: RTL and testbench
======================================

SPARSE_CHUNK_WRITER -- requirements
Module: sparse_chunk_writer

Interface
REQ-001 Parameter BUS_SIZE, default 32, is the number of byte lanes per beat.
REQ-002 Parameter WR_DAT_CYC_NUM, default 4, is the number of beats per chunk.
REQ-003 Parameter CHUNK_NUM, default 16, is the number of chunk slots in the target SRAM.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-low.
REQ-006 start_i  in  1  one-cycle pulse that launches a transfer.
REQ-007 base_chunk_i  in  $clog2(CHUNK_NUM)  first chunk slot to write.
REQ-008 chunk_len_i  in  $clog2(CHUNK_NUM)+1  number of chunks to write (0..CHUNK_NUM).
REQ-009 busy_o  out  1  high from the cycle after an accepted start until done.
REQ-010 done_o  out  1  one-cycle pulse when the transfer completes.
REQ-011 dense_valid_i  in  1  dense input beat valid.
REQ-012 dense_ready_o  out  1  block accepts the dense beat.
REQ-013 dense_data_i  in  BUS_SIZE*8  dense bytes; lane i is bits [8i+7:8i].
REQ-014 wr_sparsemap_o  out  BUS_SIZE  bit i set when dense lane i is nonzero.
REQ-015 wr_nonzero_data_o  out  BUS_SIZE*8  nonzero bytes packed from lane 0 upward.
REQ-016 wr_valid_o  out  1  write beat valid; the SRAM always accepts it.
REQ-017 wr_dat_count_o  out  $clog2(WR_DAT_CYC_NUM)  beat index within the chunk.
REQ-018 wr_chunk_count_o  out  $clog2(CHUNK_NUM)  target chunk slot.

Function
REQ-019 FSM states are IDLE, RUN and DONE, and the FSM resets to IDLE.
REQ-020 IDLE->RUN on start_i when chunk_len_i>0; the block then latches base_chunk_i and chunk_len_i.
REQ-021 IDLE->DONE on start_i when chunk_len_i==0; no write beats are issued.
REQ-022 DONE->IDLE after one cycle, and done_o is high in that cycle only.
REQ-023 start_i is ignored outside IDLE.
REQ-024 dense_ready_o = (state==RUN); a beat is accepted when dense_valid_i && dense_ready_o.
REQ-025 Each accepted beat produces exactly one write beat, registered with 1-cycle latency, with wr_valid_o high for that cycle only.
REQ-026 wr_sparsemap_o[i] = (dense lane i != 0).
REQ-027 The k-th set sparsemap bit (ascending lane order) places its byte in output lane k; unused upper lanes are 0.
REQ-028 An all-zero beat produces sparsemap 0 and data 0, and is still written.
REQ-029 wr_dat_count_o starts at 0 and increments per accepted beat.
REQ-030 After beat WR_DAT_CYC_NUM-1, wr_dat_count_o returns to 0 and wr_chunk_count_o increments.
REQ-031 wr_chunk_count_o starts at base_chunk_i and wraps modulo CHUNK_NUM.
REQ-032 After the last beat of chunk chunk_len-1 is accepted, RUN->DONE, and the final write beat coincides with done_o.
REQ-033 Input gaps (dense_valid_i low) stall the counters and produce no write beats.
REQ-034 busy_o = (state==RUN).

Reset
REQ-035 Reset forces state IDLE and clears every output and counter to 0, including wr_valid_o, done_o, busy_o and dense_ready_o.
REQ-036 Reset mid-transfer discards the partial chunk; no further write beats are issued, and a new start_i is honoured after reset is released.

Configuration
REQ-037 Macro NONZERO_COUNT_EN, when defined, adds output nz_count_o, $clog2(BUS_SIZE*WR_DAT_CYC_NUM)+1 bits wide, holding the total number of nonzero bytes in the current chunk.
REQ-038 With NONZERO_COUNT_EN defined, nz_count_o is valid with the last write beat of each chunk, holds its value until the next chunk completes, and resets to 0.
REQ-039 Without NONZERO_COUNT_EN, the nz_count_o port and its logic are absent, and all other behaviour is identical.

Verification
REQ-040 Reset, then start with base=0, len=1, and 4 beats of all 0x01 -> 4 writes, sparsemap 0xFFFFFFFF, dat_count 0..3, chunk 0, done_o on the 4th write.
REQ-041 A beat with only lanes 3 and 17 nonzero (0xAA, 0x55) -> sparsemap 0x00020008, data lane0=0xAA, lane1=0x55, other lanes 0.
REQ-042 base=14, len=3 -> chunk counts 14, 15, 0, with 12 writes total.
REQ-043 len=0 -> done_o one cycle after start, no wr_valid_o, dense_ready_o stays 0.
REQ-044 rst_i low during beat 2 of chunk 1 -> all outputs 0 the same cycle and no writes after release; a new start with base=5 writes chunk 5.
REQ-045 With NONZERO_COUNT_EN, a chunk of 4 beats containing 3, 0, 32 and 1 nonzero bytes -> nz_count_o=36 with the last write beat.

Source files
------------

// File: rtl/sparse_chunk_writer.sv
// sparse_chunk_writer: streams dense beats into chunk slots of a sparse SRAM.
// Each accepted dense beat becomes one write beat carrying a per-lane nonzero
// map and the nonzero bytes packed from lane 0 upward. A transfer writes
// chunk_len_i chunks of WR_DAT_CYC_NUM beats starting at slot base_chunk_i,
// with the slot index wrapping modulo CHUNK_NUM.
// Optional feature macro: NONZERO_COUNT_EN adds nz_count_o, the nonzero byte
// total of the most recently completed chunk.
module sparse_chunk_writer #(
  parameter int unsigned BUS_SIZE       = 32,
  parameter int unsigned WR_DAT_CYC_NUM = 4,
  parameter int unsigned CHUNK_NUM      = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [$clog2(CHUNK_NUM)-1:0]           base_chunk_i,
  input  logic [$clog2(CHUNK_NUM):0]             chunk_len_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  input  logic                                   dense_valid_i,
  output logic                                   dense_ready_o,
  input  logic [BUS_SIZE*8-1:0]                  dense_data_i,
  output logic [BUS_SIZE-1:0]                    wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                  wr_nonzero_data_o,
  output logic                                   wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]      wr_dat_count_o,
  output logic [$clog2(CHUNK_NUM)-1:0]           wr_chunk_count_o
`ifdef NONZERO_COUNT_EN
  ,
  output logic [$clog2(BUS_SIZE*WR_DAT_CYC_NUM):0] nz_count_o
`endif
);

  localparam int unsigned CW = $clog2(CHUNK_NUM);
  localparam int unsigned DW = $clog2(WR_DAT_CYC_NUM);
  localparam int unsigned LW = $clog2(CHUNK_NUM) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]         dat_cnt;
  logic [CW-1:0]         chunk_cnt;
  logic [LW-1:0]         chunks_left;
  logic                  accept;
  logic                  beat_last;
  logic                  xfer_last;
  logic                  launch;
  logic [BUS_SIZE-1:0]   sparse_map;
  logic [BUS_SIZE*8-1:0] packed_data;
  int unsigned           pack_idx;

  assign accept        = dense_valid_i && (state == RUN);
  assign beat_last     = (dat_cnt == DW'(WR_DAT_CYC_NUM - 1));
  assign xfer_last     = beat_last && (chunks_left == LW'(1));
  assign launch        = (state == IDLE) && start_i && (chunk_len_i != '0);

  assign busy_o        = (state == RUN);
  assign dense_ready_o = (state == RUN);
  assign done_o        = (state == DONE);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = (chunk_len_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept && xfer_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat / chunk position counters, loaded on launch and stepped per accepted beat
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dat_cnt     <= '0;
      chunk_cnt   <= '0;
      chunks_left <= '0;
    end else if (launch) begin
      dat_cnt     <= '0;
      chunk_cnt   <= base_chunk_i;
      chunks_left <= chunk_len_i;
    end else if (accept) begin
      if (beat_last) begin
        dat_cnt     <= '0;
        chunk_cnt   <= (chunk_cnt == CW'(CHUNK_NUM - 1)) ? '0 : chunk_cnt + CW'(1);
        chunks_left <= chunks_left - LW'(1);
      end else begin
        dat_cnt     <= dat_cnt + DW'(1);
      end
    end
  end

  // Compaction: k-th nonzero lane (ascending) lands in output lane k
  always_comb begin
    sparse_map  = '0;
    packed_data = '0;
    pack_idx    = 0;
    for (int unsigned i = 0; i < BUS_SIZE; i++) begin
      if (dense_data_i[8*i +: 8] != 8'h00) begin
        sparse_map[i]                  = 1'b1;
        packed_data[8*pack_idx +: 8]   = dense_data_i[8*i +: 8];
        pack_idx                       = pack_idx + 1;
      end
    end
  end

  // Write beat register: one-cycle latency, valid pulses once per accepted beat
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_dat_count_o    <= '0;
      wr_chunk_count_o  <= '0;
    end else begin
      wr_valid_o <= accept;
      if (accept) begin
        wr_sparsemap_o    <= sparse_map;
        wr_nonzero_data_o <= packed_data;
        wr_dat_count_o    <= dat_cnt;
        wr_chunk_count_o  <= chunk_cnt;
      end
    end
  end

`ifdef NONZERO_COUNT_EN
  localparam int unsigned NW = $clog2(BUS_SIZE*WR_DAT_CYC_NUM) + 1;
  localparam int unsigned PW = $clog2(BUS_SIZE) + 1;

  logic [PW-1:0] nz_beat;
  logic [NW-1:0] nz_acc;

  // Nonzero byte count of the current dense beat
  always_comb begin
    nz_beat = PW'($countones(sparse_map));
  end

  // Per-chunk accumulator; published together with the chunk's last write beat
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      nz_acc     <= '0;
      nz_count_o <= '0;
    end else if (launch) begin
      nz_acc     <= '0;
    end else if (accept) begin
      if (beat_last) begin
        nz_count_o <= nz_acc + NW'(nz_beat);
        nz_acc     <= '0;
      end else begin
        nz_acc     <= nz_acc + NW'(nz_beat);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// tb_sparse_chunk_writer: randomized bench for sparse_chunk_writer with a
// queue-based reference model of the compaction and chunk addressing rules.
module tb_sparse_chunk_writer;

  localparam int unsigned BUS    = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned CHUNKS = 16;
  localparam int unsigned DWID   = BUS*8;
  localparam int unsigned CW     = $clog2(CHUNKS);
  localparam int unsigned LW     = $clog2(CHUNKS) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [CW-1:0]     base_chunk_i;
  logic [LW-1:0]     chunk_len_i;
  logic              busy_o;
  logic              done_o;
  logic              dense_valid_i;
  logic              dense_ready_o;
  logic [DWID-1:0]   dense_data_i;
  logic [BUS-1:0]    wr_sparsemap_o;
  logic [DWID-1:0]   wr_nonzero_data_o;
  logic              wr_valid_o;
  logic [$clog2(BEATS)-1:0] wr_dat_count_o;
  logic [CW-1:0]     wr_chunk_count_o;
`ifdef NONZERO_COUNT_EN
  logic [$clog2(BUS*BEATS):0] nz_count_o;
  int unsigned       last_nz = 0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sparse_chunk_writer #(
    .BUS_SIZE(BUS),
    .WR_DAT_CYC_NUM(BEATS),
    .CHUNK_NUM(CHUNKS)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .base_chunk_i(base_chunk_i),
    .chunk_len_i(chunk_len_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .dense_valid_i(dense_valid_i),
    .dense_ready_o(dense_ready_o),
    .dense_data_i(dense_data_i),
    .wr_sparsemap_o(wr_sparsemap_o),
    .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o),
    .wr_dat_count_o(wr_dat_count_o),
    .wr_chunk_count_o(wr_chunk_count_o)
`ifdef NONZERO_COUNT_EN
    ,
    .nz_count_o(nz_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [DWID-1:0] got, input logic [DWID-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DWID-1:0] rand_bus();
    logic [DWID-1:0] r;
    for (int i = 0; i < DWID/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Dense beat generator: 0 random sparse, 1 all 0x01, 2 lanes 3/17 only,
  // 3 nonzero-count pattern 3,0,32,1 per beat
  function automatic logic [DWID-1:0] gen_beat(input int unsigned mode, input int unsigned beat);
    logic [DWID-1:0] d;
    int unsigned     cnt;
    d = '0;
    case (mode)
      1: for (int i = 0; i < BUS; i++) d[8*i +: 8] = 8'h01;
      2: begin
        d[8*3 +: 8]  = 8'hAA;
        d[8*17 +: 8] = 8'h55;
      end
      3: begin
        cnt = (beat == 0) ? 3 : (beat == 1) ? 0 : (beat == 2) ? 32 : 1;
        for (int i = 0; i < BUS; i++)
          if (i < cnt) d[8*i +: 8] = 8'($urandom_range(1, 255));
      end
      default: begin
        if ($urandom_range(0, 7) != 0)
          for (int i = 0; i < BUS; i++)
            if ($urandom_range(0, 2) == 0) d[8*i +: 8] = 8'($urandom_range(1, 255));
      end
    endcase
    return d;
  endfunction

  // Reference: collect nonzero bytes in lane order, then lay them out from lane 0
  task automatic model_pack(input logic [DWID-1:0] d, output logic [BUS-1:0] m,
                            output logic [DWID-1:0] p, output int unsigned n);
    byte unsigned nz[$];
    byte unsigned b;
    m = '0;
    p = '0;
    for (int i = 0; i < BUS; i++) begin
      b = d[8*i +: 8];
      if (b != 0) begin
        m[i] = 1'b1;
        nz.push_back(b);
      end
    end
    foreach (nz[k]) p[8*k +: 8] = nz[k];
    n = nz.size();
  endtask

  task automatic do_transfer(input int unsigned base, input int unsigned len, input int unsigned mode);
    int unsigned     total, sent, cyc, nz_acc, e_n;
    logic            acc, last;
    logic [BUS-1:0]  e_map;
    logic [DWID-1:0] e_data;
    int unsigned     e_dat, e_chunk;
    total  = len * BEATS;
    sent   = 0;
    cyc    = 0;
    nz_acc = 0;
    last   = 1'b0;
    e_map = '0; e_data = '0; e_dat = 0; e_chunk = 0; e_n = 0;
    start_i       = 1'b1;
    base_chunk_i  = CW'(base);
    chunk_len_i   = LW'(len);
    dense_valid_i = 1'b0;
    dense_data_i  = rand_bus();
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check_eq("start_done", done_o, len == 0);
    check_eq("start_busy", busy_o, len != 0);
    check_eq("start_ready", dense_ready_o, len != 0);
    check_eq("start_wr_valid", wr_valid_o, 0);
    while (sent < total && cyc < 2000) begin
      acc = ($urandom_range(0, 3) != 0);
      dense_valid_i = acc;
      if (acc) begin
        dense_data_i = gen_beat(mode, sent % BEATS);
        model_pack(dense_data_i, e_map, e_data, e_n);
        e_dat   = sent % BEATS;
        e_chunk = (base + sent / BEATS) % CHUNKS;
        last    = (sent == total - 1);
      end else begin
        dense_data_i = rand_bus();
      end
      if ($urandom_range(0, 7) == 0) begin
        start_i      = 1'b1;
        base_chunk_i = CW'($urandom);
        chunk_len_i  = LW'($urandom_range(0, CHUNKS));
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc++;
      check_eq("wr_valid", wr_valid_o, acc);
      if (acc) begin
        sent++;
        check_eq("sparsemap", wr_sparsemap_o, e_map);
        check_eq("nonzero_data", wr_nonzero_data_o, e_data);
        check_eq("dat_count", wr_dat_count_o, e_dat);
        check_eq("chunk_count", wr_chunk_count_o, e_chunk);
        nz_acc += e_n;
        if (sent % BEATS == 0) begin
`ifdef NONZERO_COUNT_EN
          check_eq("nz_count", nz_count_o, nz_acc);
          last_nz = nz_acc;
`endif
          nz_acc = 0;
        end
      end
      check_eq("done", done_o, acc && last);
      check_eq("busy", busy_o, sent < total);
      check_eq("ready", dense_ready_o, sent < total);
    end
    if (sent < total) check_eq("transfer_timeout", sent, total);
    dense_valid_i = 1'b1;
    dense_data_i  = rand_bus();
    @(posedge clk_i); #1;
    dense_valid_i = 1'b0;
    check_eq("idle_done", done_o, 0);
    check_eq("idle_busy", busy_o, 0);
    check_eq("idle_ready", dense_ready_o, 0);
    check_eq("idle_wr_valid", wr_valid_o, 0);
`ifdef NONZERO_COUNT_EN
    check_eq("nz_count_hold", nz_count_o, last_nz);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_ready"}, dense_ready_o, 0);
    check_eq({tag, "_wr_valid"}, wr_valid_o, 0);
    check_eq({tag, "_map"}, wr_sparsemap_o, 0);
    check_eq({tag, "_data"}, wr_nonzero_data_o, 0);
    check_eq({tag, "_dat_cnt"}, wr_dat_count_o, 0);
    check_eq({tag, "_chunk_cnt"}, wr_chunk_count_o, 0);
`ifdef NONZERO_COUNT_EN
    check_eq({tag, "_nz_count"}, nz_count_o, 0);
`endif
  endtask

  initial begin
    rst_i         = 1'b0;
    start_i       = 1'b0;
    base_chunk_i  = '0;
    chunk_len_i   = '0;
    dense_valid_i = 1'b0;
    dense_data_i  = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    do_transfer(0, 1, 1);
    do_transfer(2, 1, 2);
    do_transfer(14, 3, 0);
    do_transfer(0, 0, 0);
    do_transfer(7, 1, 3);
    do_transfer(3, 16, 0);

    // Reset in the middle of chunk 1, beat 2
    start_i      = 1'b1;
    base_chunk_i = CW'(9);
    chunk_len_i  = LW'(3);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int b = 0; b < 6; b++) begin
      dense_valid_i = 1'b1;
      dense_data_i  = gen_beat(0, 0);
      @(posedge clk_i); #1;
      check_eq("pre_reset_wr_valid", wr_valid_o, 1);
    end
    dense_data_i = gen_beat(1, 0);
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      check_eq("post_reset_wr_valid", wr_valid_o, 0);
      check_eq("post_reset_busy", busy_o, 0);
    end
    dense_valid_i = 1'b0;
    do_transfer(5, 1, 0);

    for (int t = 0; t < 8; t++)
      do_transfer($urandom_range(0, CHUNKS - 1), $urandom_range(0, 5), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
